uart_msg_deframer: RTL

Parametrised UART message receiver for the test harness. It sits between the `uart_rx_pin` input and the harness command decoder. It oversamples the line with a majority vote to reject short glitches, assembles LSB-word-first UART words into a `MSG_WIDTH` message, and splits each message into header and payload. Partial messages are dropped on a timeout or a framing error, and complete messages are handed off through a valid/ready handshake.

---
 rtl/uart_msg_deframer_pkg.sv | 27 ++
 rtl/uart_msg_deframer_if.sv | 29 ++
 rtl/uart_msg_deframer_rx_majority.sv | 127 ++++++++++++
 rtl/uart_msg_deframer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_msg_deframer_pkg.sv
// Shared types and constants for the UART message deframer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package uart_msg_pkg;

  // Bit receiver states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DEF_CLK_RATE = 108_000_000;
  localparam int DEF_BAUD     = 9600;

  // Clocks per bit period.
  function automatic int calc_cpb(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  // Spacing between the three majority-vote samples of one bit.
  function automatic int calc_q(input int clk_rate, input int baud);
    return calc_cpb(clk_rate, baud) / 8;
  endfunction

endpackage

// File: rtl/uart_msg_deframer_if.sv
// Message output bundle: payload handshake plus the one-cycle error pulses.
// Latency: n/a (wires only).
// Backpressure: msg_valid is held with stable data until msg_valid && msg_ready.
// Ports: master drives msg_valid/msg_header/msg_payload/error pulses, slave drives msg_ready.
interface uart_msg_deframer_if #(
  parameter int HEADER_WIDTH  = 8,
  parameter int PAYLOAD_WIDTH = 56
);
  logic                     msg_valid;
  logic                     msg_ready;
  logic [HEADER_WIDTH-1:0]  msg_header;
  logic [PAYLOAD_WIDTH-1:0] msg_payload;
  logic                     frame_err;
  logic                     timeout_err;
  logic                     overflow;
  logic                     chk_err;

  modport master (
    output msg_valid, msg_header, msg_payload,
    output frame_err, timeout_err, overflow, chk_err,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_header, msg_payload,
    input  frame_err, timeout_err, overflow, chk_err,
    output msg_ready
  );
endinterface

// File: rtl/uart_msg_deframer_rx_majority.sv
// UART word receiver: 2-flop synchroniser, start/data/stop state machine, 3-sample majority vote per bit.
// Latency: word_valid/frame_err are combinational in the cycle of the final stop-bit vote.
// Backpressure: none; the consumer must take word_valid when it is asserted.
// Ports: clk, n_reset (sync, active-low), rx (async line) -> word_valid, word, frame_err.
module uart_rx_majority
  import uart_msg_pkg::*;
#(
  parameter int CLK_RATE   = DEF_CLK_RATE,
  parameter int BAUD       = DEF_BAUD,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  rx,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  frame_err
);

  localparam int CPB   = calc_cpb(CLK_RATE, BAUD);
  localparam int Q     = calc_q(CLK_RATE, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  // Sample points within one bit period, counted from the detected falling edge.
  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(CPB / 2 - Q);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0] C_S2   = CNT_W'(CPB / 2 + Q);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] B_DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] B_STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic                  rx_meta, rx_sync, rx_prev;
  rx_state_t             state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [BIT_W-1:0]      bit_idx, bit_idx_nx;
  logic [1:0]            votes, votes_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  maj;

  // Third vote is taken live, so the bit decision lands on the last sample cycle.
  assign maj  = (votes[1] & votes[0]) | (votes[1] & rx_sync) | (votes[0] & rx_sync);
  assign word = shreg;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      votes   <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      votes   <= votes_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    votes_nx   = votes;
    shreg_nx   = shreg;
    word_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == ST_IDLE) begin
      cnt_nx     = '0;
      bit_idx_nx = '0;
      // The detection cycle is offset 0, so the first START cycle is offset 1.
      if (rx_prev && !rx_sync) begin
        state_nx = ST_START;
        cnt_nx   = CNT_W'(1);
      end
    end else begin
      cnt_nx = (cnt == C_LAST) ? '0 : cnt + CNT_W'(1);
      if (cnt == C_S0 || cnt == C_S1) begin
        votes_nx = {votes[0], rx_sync};
      end
      if (cnt == C_S2) begin
        case (state)
          ST_START: if (maj) state_nx = ST_IDLE;  // glitch, not a start bit
          ST_DATA:  shreg_nx = DATA_WIDTH'({maj, shreg} >> 1);
          ST_STOP: begin
            if (!maj) begin
              frame_err = 1'b1;
              state_nx  = ST_IDLE;
            end else if (bit_idx == B_STOP_LAST) begin
              // Remaining stop-bit time is ignored so a back-to-back start is caught.
              word_valid = 1'b1;
              state_nx   = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
      if (cnt == C_LAST) begin
        case (state)
          ST_START: begin
            state_nx   = ST_DATA;
            bit_idx_nx = '0;
          end
          ST_DATA: begin
            if (bit_idx == B_DATA_LAST) begin
              state_nx   = ST_STOP;
              bit_idx_nx = '0;
            end else begin
              bit_idx_nx = bit_idx + BIT_W'(1);
            end
          end
          ST_STOP: bit_idx_nx = bit_idx + BIT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_msg_deframer.sv
// UART message deframer: assembles LSB-word-first UART words into a message and splits it into header/payload.
// Latency: msg_valid rises the cycle after the final stop-bit vote of the last word (checksum word when enabled).
// Backpressure: output held until msg_valid && msg_ready; a message completing while held and not ready is dropped with overflow.
// Ports: clk, n_reset (sync, active-low), rx (async line), msg_if (master: message handshake and error pulses).
// Optional build macro UART_MSG_RX_CHECKSUM_EN: expect a trailing XOR checksum word and pulse chk_err on mismatch.
module uart_msg_deframer
  import uart_msg_pkg::*;
#(
  parameter int CLK_RATE      = DEF_CLK_RATE,
  parameter int BAUD          = DEF_BAUD,
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int MSG_WIDTH     = 64,
  parameter int HEADER_WIDTH  = 8,
  parameter int TIMEOUT_BAUDS = 20
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 rx,
  uart_msg_deframer_if.master  msg_if
);

  localparam int CPB        = calc_cpb(CLK_RATE, BAUD);
  localparam int WORDS      = MSG_WIDTH / DATA_WIDTH;
  localparam int WC_W       = $clog2(WORDS + 1);
  localparam int IDLE_LIMIT = TIMEOUT_BAUDS * CPB;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
`ifdef UART_MSG_RX_CHECKSUM_EN
  localparam int LAST_WORD  = WORDS;
`else
  localparam int LAST_WORD  = WORDS - 1;
`endif

  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  logic                  rx_frame_err;

  logic [WC_W-1:0]       wc;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [MSG_WIDTH-1:0]  msg_sh, msg_shift, msg_done;
  logic                  last_word, chk_bad, complete, timeout_hit;

  logic                            msg_valid_q;
  logic [HEADER_WIDTH-1:0]         hdr_q;
  logic [MSG_WIDTH-HEADER_WIDTH-1:0] pay_q;
  logic                            frame_err_q, timeout_err_q, overflow_q;

  uart_rx_majority #(
    .CLK_RATE   (CLK_RATE),
    .BAUD       (BAUD),
    .DATA_WIDTH (DATA_WIDTH),
    .STOP_BITS  (STOP_BITS)
  ) u_rx (
    .clk        (clk),
    .n_reset    (n_reset),
    .rx         (rx),
    .word_valid (word_valid),
    .word       (word),
    .frame_err  (rx_frame_err)
  );

  // New words enter at the top, so the first word ends at the bottom.
  assign msg_shift = MSG_WIDTH'({word, msg_sh} >> DATA_WIDTH);
  assign last_word = word_valid && (wc == WC_W'(LAST_WORD));

`ifdef UART_MSG_RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_acc;
  logic                  chk_err_q;

  // The message is already whole in msg_sh when the checksum word arrives.
  assign msg_done = msg_sh;
  assign chk_bad  = last_word && (word != xor_acc);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      xor_acc   <= '0;
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_bad;
      if (rx_frame_err || timeout_hit || last_word) xor_acc <= '0;
      else if (word_valid)                          xor_acc <= xor_acc ^ word;
    end
  end

  assign msg_if.chk_err = chk_err_q;
`else
  assign msg_done       = msg_shift;
  assign chk_bad        = 1'b0;
  assign msg_if.chk_err = 1'b0;
`endif

  assign complete = last_word && !chk_bad;
  // A delivered word or a framing error in the same cycle takes precedence over the timeout.
  assign timeout_hit = !rx_frame_err && !word_valid && (wc != '0) &&
                       (idle_cnt == IDLE_W'(IDLE_LIMIT));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wc            <= '0;
      idle_cnt      <= '0;
      msg_sh        <= '0;
      msg_valid_q   <= 1'b0;
      hdr_q         <= '0;
      pay_q         <= '0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      frame_err_q   <= rx_frame_err;
      timeout_err_q <= timeout_hit;
      overflow_q    <= complete && msg_valid_q && !msg_if.msg_ready;

      if (rx_frame_err || timeout_hit || last_word) begin
        wc     <= '0;
        msg_sh <= '0;
      end else if (word_valid) begin
        wc     <= wc + WC_W'(1);
        msg_sh <= msg_shift;
      end

      if (word_valid || wc == '0)                  idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(IDLE_LIMIT))    idle_cnt <= idle_cnt + IDLE_W'(1);

      // A completion coinciding with a handshake replaces the outgoing message.
      if (complete && (!msg_valid_q || msg_if.msg_ready)) begin
        msg_valid_q <= 1'b1;
        hdr_q       <= msg_done[MSG_WIDTH-1 -: HEADER_WIDTH];
        pay_q       <= msg_done[MSG_WIDTH-HEADER_WIDTH-1:0];
      end else if (msg_valid_q && msg_if.msg_ready) begin
        msg_valid_q <= 1'b0;
      end
    end
  end

  assign msg_if.msg_valid   = msg_valid_q;
  assign msg_if.msg_header  = hdr_q;
  assign msg_if.msg_payload = pay_q;
  assign msg_if.frame_err   = frame_err_q;
  assign msg_if.timeout_err = timeout_err_q;
  assign msg_if.overflow    = overflow_q;

endmodule
